// File: rtl/uart_tx_ctrl_pkg.sv
// Shared types and constants for the UART transmit sequencer.
// Holds the FSM state encoding, TX output mux selects and the control-strobe bundle.
package uart_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP1  = 3'd5,
    STOP2  = 3'd6
  } tx_state_t;

  localparam logic [1:0] TX_OUT_SPACE  = 2'b00;
  localparam logic [1:0] TX_OUT_MARK   = 2'b01;
  localparam logic [1:0] TX_OUT_DATA   = 2'b10;
  localparam logic [1:0] TX_OUT_PARITY = 2'b11;

  typedef struct packed {
    logic       queue_re;
    logic       shift_reg_we;
    logic       shift_reg_se;
    logic       bits_cnt_en;
    logic       bits_cnt_reset;
    logic       parity_we;
    logic       parity_reset;
    logic [1:0] out_sel;
    logic       busy;
    logic       frame_done;
  } tx_ctrl_out_t;

  // Every state starts from the quiet idle pattern and overrides what it needs.
  localparam tx_ctrl_out_t TX_CTRL_IDLE = '{
    queue_re:       1'b0,
    shift_reg_we:   1'b0,
    shift_reg_se:   1'b0,
    bits_cnt_en:    1'b0,
    bits_cnt_reset: 1'b1,
    parity_we:      1'b0,
    parity_reset:   1'b1,
    out_sel:        TX_OUT_MARK,
    busy:           1'b0,
    frame_done:     1'b0
  };

  function automatic logic frame_may_start(input logic tx_en, input logic tx_queue_empty);
    return tx_en && !tx_queue_empty;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Control bundle between the UART transmit sequencer and the UART datapath.
// master = sequencer side, slave = datapath side.
interface uart_tx_ctrl_if;

  logic       bit_clk_cnt_top;
  logic       tx_queue_empty;
  logic       tx_bits_cnt_top;
  logic       tx_en;
  logic       parity_en;
  logic       double_stop;

  logic       tx_queue_re;
  logic       tx_shift_reg_we;
  logic       tx_shift_reg_se;
  logic       tx_bits_cnt_en;
  logic       tx_bits_cnt_reset;
  logic       tx_parity_we;
  logic       tx_parity_reset;
  logic [1:0] tx_out_sel;
  logic       busy;
  logic       frame_done;

  modport master (
    input  bit_clk_cnt_top, tx_queue_empty, tx_bits_cnt_top,
    input  tx_en, parity_en, double_stop,
    output tx_queue_re, tx_shift_reg_we, tx_shift_reg_se,
    output tx_bits_cnt_en, tx_bits_cnt_reset,
    output tx_parity_we, tx_parity_reset,
    output tx_out_sel, busy, frame_done
  );

  modport slave (
    output bit_clk_cnt_top, tx_queue_empty, tx_bits_cnt_top,
    output tx_en, parity_en, double_stop,
    input  tx_queue_re, tx_shift_reg_we, tx_shift_reg_se,
    input  tx_bits_cnt_en, tx_bits_cnt_reset,
    input  tx_parity_we, tx_parity_reset,
    input  tx_out_sel, busy, frame_done
  );

endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops a byte, then walks start, data, optional parity
// and one or two stop bits, one bit period per datapath tick.
//
// state  | meaning
// IDLE   | line at mark, bit counter and parity held in preset
// LOAD   | one cycle: pop FIFO, load shift register, start bit begins
// START  | start bit (space) until the next tick
// DATA   | shift LSB out; each tick shifts, counts and accumulates parity
// PARITY | parity bit on the line
// STOP1  | first stop bit (mark)
// STOP2  | second stop bit (mark), only with double_stop
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int STOP_BITS_MAX = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_tx_ctrl_if.master tx_if
);

  tx_state_t    state;
  tx_state_t    state_nxt;
  tx_ctrl_out_t ctl;

  logic tick;
  logic next_frame;
  logic stop2_sel;
  logic last_stop_tick;

  assign tick       = tx_if.bit_clk_cnt_top;
  assign next_frame = frame_may_start(tx_if.tx_en, tx_if.tx_queue_empty);
  assign stop2_sel  = tx_if.double_stop && (STOP_BITS_MAX > 1);

  assign last_stop_tick = tick && (((state == STOP1) && !stop2_sel) || (state == STOP2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (tick && next_frame) begin
          state_nxt = LOAD;
        end
      end
      // A tick landing on LOAD is deliberately ignored; the start bit is
      // measured from LOAD to the next tick.
      LOAD: begin
        state_nxt = START;
      end
      START: begin
        if (tick) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (tick && tx_if.tx_bits_cnt_top) begin
          state_nxt = tx_if.parity_en ? PARITY : STOP1;
        end
      end
      PARITY: begin
        if (tick) begin
          state_nxt = STOP1;
        end
      end
      STOP1: begin
        if (tick) begin
          if (stop2_sel) begin
            state_nxt = STOP2;
          end else begin
            state_nxt = next_frame ? LOAD : IDLE;
          end
        end
      end
      STOP2: begin
        if (tick) begin
          state_nxt = next_frame ? LOAD : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    ctl = TX_CTRL_IDLE;
    case (state)
      IDLE: begin
        ctl = TX_CTRL_IDLE;
      end
      LOAD: begin
        ctl.busy           = 1'b1;
        ctl.queue_re       = 1'b1;
        ctl.shift_reg_we   = 1'b1;
        ctl.bits_cnt_reset = 1'b1;
        ctl.parity_reset   = 1'b1;
        ctl.out_sel        = TX_OUT_SPACE;
      end
      START: begin
        ctl.busy           = 1'b1;
        ctl.bits_cnt_reset = 1'b0;
        ctl.parity_reset   = 1'b0;
        ctl.out_sel        = TX_OUT_SPACE;
      end
      // Parity samples the pre-shift LSB, so all three strobes share the tick.
      DATA: begin
        ctl.busy           = 1'b1;
        ctl.bits_cnt_reset = 1'b0;
        ctl.parity_reset   = 1'b0;
        ctl.out_sel        = TX_OUT_DATA;
        ctl.parity_we      = tick;
        ctl.shift_reg_se   = tick;
        ctl.bits_cnt_en    = tick;
      end
      PARITY: begin
        ctl.busy           = 1'b1;
        ctl.bits_cnt_reset = 1'b0;
        ctl.parity_reset   = 1'b0;
        ctl.out_sel        = TX_OUT_PARITY;
      end
      STOP1, STOP2: begin
        ctl.busy           = 1'b1;
        ctl.bits_cnt_reset = 1'b0;
        ctl.parity_reset   = 1'b0;
        ctl.out_sel        = TX_OUT_MARK;
        ctl.frame_done     = last_stop_tick;
      end
      default: begin
        ctl = TX_CTRL_IDLE;
      end
    endcase
  end

  assign tx_if.tx_queue_re       = ctl.queue_re;
  assign tx_if.tx_shift_reg_we   = ctl.shift_reg_we;
  assign tx_if.tx_shift_reg_se   = ctl.shift_reg_se;
  assign tx_if.tx_bits_cnt_en    = ctl.bits_cnt_en;
  assign tx_if.tx_bits_cnt_reset = ctl.bits_cnt_reset;
  assign tx_if.tx_parity_we      = ctl.parity_we;
  assign tx_if.tx_parity_reset   = ctl.parity_reset;
  assign tx_if.tx_out_sel        = ctl.out_sel;
  assign tx_if.busy              = ctl.busy;
  assign tx_if.frame_done        = ctl.frame_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: models the datapath tick, FIFO and bit counter,
// and scoreboards the per-bit-period line state against queued expected frames.
module tb_uart_tx_ctrl;

  logic clk;
  logic reset_n;

  uart_tx_ctrl_if tx_if();

  uart_tx_ctrl #(.STOP_BITS_MAX(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tx_if   (tx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [1:0] exp_q[$];

  int ph = 0;
  bit tick_run = 1'b1;
  bit inject_load = 1'b0;
  bit load_next = 1'b0;
  bit extra_now = 1'b0;
  bit prev_done = 1'b0;
  bit prev_busy = 1'b0;
  int q_pushed = 0;
  int q_popped = 0;
  int bit_cnt = 0;

  int n_re = 0, n_we = 0, n_se = 0, n_pwe = 0, n_done = 0, n_bits = 0;
  int n_space = 0, n_b2b = 0, n_gap = 0, n_re_empty = 0, n_inject_load = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input bit par, input bit ds);
    exp_q.push_back(2'b00);
    for (int i = 0; i < 8; i++) exp_q.push_back(2'b10);
    if (par) exp_q.push_back(2'b11);
    exp_q.push_back(2'b01);
    if (ds) exp_q.push_back(2'b01);
  endtask

  // One clock: drive inputs at the falling edge, sample just after, book-keep
  // what the coming rising edge will do.
  task automatic step();
    logic [1:0] e;
    @(negedge clk);
    ph = (ph + 1) % 4;
    extra_now = inject_load && load_next && !(tick_run && ph == 0);
    tx_if.bit_clk_cnt_top = (tick_run && ph == 0) || extra_now;
    tx_if.tx_queue_empty  = (q_pushed == q_popped);
    tx_if.tx_bits_cnt_top = (bit_cnt == 7);
    #1;
    if (tx_if.bit_clk_cnt_top && tx_if.busy && !extra_now) begin
      check("sb_depth", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("bit_out_sel", tx_if.tx_out_sel, e);
      end
      n_bits++;
    end
    if (extra_now && tx_if.tx_shift_reg_we) n_inject_load++;
    load_next = tx_if.bit_clk_cnt_top && !tx_if.busy && tx_if.tx_en && !tx_if.tx_queue_empty;
    if (tx_if.tx_queue_re && (q_pushed == q_popped)) n_re_empty++;
    if (tx_if.tx_queue_re) begin n_re++; q_popped++; end
    if (tx_if.tx_shift_reg_we) begin
      n_we++;
      if (prev_done) n_b2b++;
    end
    if (tx_if.tx_shift_reg_se) n_se++;
    if (tx_if.tx_parity_we) n_pwe++;
    if (tx_if.frame_done) n_done++;
    if (tx_if.busy && tx_if.tx_out_sel == 2'b00) n_space++;
    if (prev_busy && !tx_if.busy && exp_q.size() != 0) n_gap++;
    if (tx_if.tx_bits_cnt_reset) bit_cnt = 0;
    else if (tx_if.tx_bits_cnt_en) bit_cnt++;
    prev_done = tx_if.frame_done;
    prev_busy = tx_if.busy;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    step();
    while ((exp_q.size() != 0 || tx_if.busy) && n < budget) begin
      step();
      n++;
    end
    check("run_timeout", (n < budget), 1);
  endtask

  task automatic step_until_se(input int target, input int budget);
    int n;
    n = 0;
    while (n_se < target && n < budget) begin
      step();
      n++;
    end
    check("se_wait_timeout", (n < budget), 1);
  endtask

  int re0, we0, se0, pwe0, done0, bits0, n_wait;

  task automatic snap();
    re0 = n_re; we0 = n_we; se0 = n_se; pwe0 = n_pwe; done0 = n_done; bits0 = n_bits;
    n_space = 0; n_b2b = 0; n_gap = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    tx_if.bit_clk_cnt_top = 1'b0;
    tx_if.tx_queue_empty  = 1'b1;
    tx_if.tx_bits_cnt_top = 1'b0;
    tx_if.tx_en           = 1'b0;
    tx_if.parity_en       = 1'b0;
    tx_if.double_stop     = 1'b0;

    // Reset state
    step(); step();
    check("rst_out_sel", tx_if.tx_out_sel, 2'b01);
    check("rst_bits_cnt_reset", tx_if.tx_bits_cnt_reset, 1);
    check("rst_parity_reset", tx_if.tx_parity_reset, 1);
    check("rst_busy", tx_if.busy, 0);
    check("rst_strobes", {tx_if.tx_queue_re, tx_if.tx_shift_reg_we, tx_if.tx_shift_reg_se,
                          tx_if.tx_bits_cnt_en, tx_if.tx_parity_we, tx_if.frame_done}, 0);
    reset_n = 1'b1;
    step(); step();

    // 8N1 single frame
    tx_if.tx_en = 1'b1;
    snap();
    push_frame(1'b0, 1'b0);
    q_pushed++;
    run_until_idle(200);
    check("8n1_re", n_re - re0, 1);
    check("8n1_we", n_we - we0, 1);
    check("8n1_se", n_se - se0, 8);
    check("8n1_pwe", n_pwe - pwe0, 8);
    check("8n1_done", n_done - done0, 1);
    check("8n1_bits", n_bits - bits0, 10);
    check("8n1_start_cycles", n_space, 4);

    // 8E2 single frame
    tx_if.parity_en = 1'b1;
    tx_if.double_stop = 1'b1;
    snap();
    push_frame(1'b1, 1'b1);
    q_pushed++;
    run_until_idle(200);
    check("8e2_re", n_re - re0, 1);
    check("8e2_pwe", n_pwe - pwe0, 8);
    check("8e2_se", n_se - se0, 8);
    check("8e2_done", n_done - done0, 1);
    check("8e2_bits", n_bits - bits0, 12);

    // Back-to-back 8N1 x3
    tx_if.parity_en = 1'b0;
    tx_if.double_stop = 1'b0;
    snap();
    for (int i = 0; i < 3; i++) push_frame(1'b0, 1'b0);
    q_pushed += 3;
    run_until_idle(400);
    check("b2b_re", n_re - re0, 3);
    check("b2b_done", n_done - done0, 3);
    check("b2b_bits", n_bits - bits0, 30);
    check("b2b_loads_after_done", n_b2b, 2);
    check("b2b_busy_gaps", n_gap, 0);

    // tx_en dropped during data bit 3
    snap();
    push_frame(1'b0, 1'b0);
    q_pushed += 2;
    step_until_se(se0 + 2, 100);
    tx_if.tx_en = 1'b0;
    run_until_idle(200);
    for (int i = 0; i < 12; i++) step();
    check("txen_busy", tx_if.busy, 0);
    check("txen_queue_left", q_pushed - q_popped, 1);
    check("txen_re", n_re - re0, 1);
    check("txen_done", n_done - done0, 1);
    tx_if.tx_en = 1'b1;
    push_frame(1'b0, 1'b0);
    n_wait = 0;
    while (n_we == we0 + 1 && n_wait < 20) begin
      step();
      n_wait++;
    end
    check("txen_restart_latency", (n_wait <= 5), 1);
    run_until_idle(200);
    check("txen_total_bits", n_bits - bits0, 20);

    // Tick coincident with LOAD
    snap();
    inject_load = 1'b1;
    push_frame(1'b0, 1'b0);
    q_pushed++;
    run_until_idle(200);
    inject_load = 1'b0;
    check("ldtick_seen", n_inject_load, 1);
    check("ldtick_start_cycles", n_space, 4);
    check("ldtick_bits", n_bits - bits0, 10);

    // Reset mid-DATA
    snap();
    push_frame(1'b0, 1'b0);
    q_pushed++;
    step_until_se(se0 + 2, 100);
    reset_n = 1'b0;
    #1;
    check("arst_out_sel", tx_if.tx_out_sel, 2'b01);
    check("arst_busy", tx_if.busy, 0);
    check("arst_frame_done", tx_if.frame_done, 0);
    exp_q.delete();
    step(); step();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("arst_idle_busy", tx_if.busy, 0);
    check("arst_re", n_re - re0, 1);
    check("arst_done", n_done - done0, 0);

    check("re_while_empty", n_re_empty, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
